// File: rtl/seg7_time_scan.sv
// Scans a 4-digit common-anode MM:SS display from a per-frame snapshot of the BCD time.
// Registered outputs follow the digit index and blink phase one Clk later.
module seg7_time_scan #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 125
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic       blink_en,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   snap;
    logic [BW-1:0] bcnt;
    logic          phase_on;
    logic          tick;
    logic          wrap;

    logic [3:0]    nib;
    logic          blank;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign tick       = (presc == PRESC_LAST);
    assign wrap       = tick && (idx == 2'd3);
    assign frame_done = wrap;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // Inputs are sampled only at the frame wrap so a scan never mixes two time values.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            snap <= 16'h0000;
        end else if (wrap) begin
            snap <= {min_bcd, sec_bcd};
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            bcnt     <= '0;
            phase_on <= 1'b1;
        end else if (!blink_en) begin
            bcnt     <= '0;
            phase_on <= 1'b1;
        end else if (tick) begin
            if (bcnt == BLINK_LAST) begin
                bcnt     <= '0;
                phase_on <= ~phase_on;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        nib = snap[3:0];
        case (idx)
            2'd0: nib = snap[3:0];
            2'd1: nib = snap[7:4];
            2'd2: nib = snap[11:8];
            2'd3: nib = snap[15:12];
            default: nib = snap[3:0];
        endcase
    end

    always_comb begin
        blank = (blink_en && !phase_on) ||
                ((idx == 2'd3) && blank_lz && (snap[15:12] == 4'd0));
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = decode(nib);
            // Colon sits on the minute-units digit.
            dp_d  = (idx != 2'd2);
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
